// File: rtl/rect_fill_master.sv
// rect_fill_master: bus master that fills an axis-aligned rectangle of the frame
// buffer with a single PIXEL value. The rectangle is sent row by row over an
// 8-bit register bus:
//   B3 <- colour (optional), B1 <- row, then per pixel B0 <- column, B2 <- pixel.
//
// Optional feature: define RECT_FILL_COLOUR_EN to issue one B3 write of COLOUR
// at the start of every accepted, non-rejected fill.
//
// Parameters
//   X_MAX  last valid frame-buffer column
//   Y_MAX  last valid frame-buffer row
// Ports
//   CLK           clock, rising edge
//   Reset         asynchronous active-high reset
//   START         fill request, sampled only in the idle state
//   X0, X1        inclusive column bounds (X1 clamped to X_MAX)
//   Y0, Y1        inclusive row bounds (Y1 clamped to Y_MAX), sent unmodified
//   PIXEL         value written to every pixel
//   COLOUR        colour byte for B3 (unused unless RECT_FILL_COLOUR_EN)
//   GRANT         bus grant; a write is only issued while high
//   BUS_ADDR      bus address, 8'hFF when no write
//   BUS_DATA_OUT  write data, 8'h00 when no write
//   BUS_DATA_OE   drive enable for the top-level tristate
//   BUS_WE        high in write cycles
//   BUSY          operation in progress
//   DONE          one-cycle completion pulse
//   ERR           qualifies DONE: rectangle rejected, nothing written
module rect_fill_master #(
  parameter int unsigned X_MAX = 159,
  parameter int unsigned Y_MAX = 119
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       START,
  input  logic [7:0] X0,
  input  logic [7:0] X1,
  input  logic [6:0] Y0,
  input  logic [6:0] Y1,
  input  logic       PIXEL,
  input  logic [7:0] COLOUR,
  input  logic       GRANT,
  output logic [7:0] BUS_ADDR,
  output logic [7:0] BUS_DATA_OUT,
  output logic       BUS_DATA_OE,
  output logic       BUS_WE,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  localparam logic [7:0] XMaxC = 8'(X_MAX);
  localparam logic [6:0] YMaxC = 7'(Y_MAX);

  localparam logic [7:0] AddrCol    = 8'hB0;
  localparam logic [7:0] AddrRow    = 8'hB1;
  localparam logic [7:0] AddrPix    = 8'hB2;
  localparam logic [7:0] AddrColour = 8'hB3;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
`ifdef RECT_FILL_COLOUR_EN
    StColour = 3'd1,
`endif
    StWrY    = 3'd2,
    StWrX    = 3'd3,
    StWrPix  = 3'd4,
    StFin    = 3'd5
  } state_e;

`ifdef RECT_FILL_COLOUR_EN
  localparam state_e StFirst = StColour;
`else
  localparam state_e StFirst = StWrY;
`endif

  state_e     state_q, state_d;
  logic [7:0] x0_q, x0_d;
  logic [7:0] x1_q, x1_d;
  logic [6:0] y1_q, y1_d;
  logic [7:0] col_q, col_d;
  logic [6:0] row_q, row_d;
  logic       pixel_q, pixel_d;
  logic       err_q, err_d;

  logic [7:0] x1_clamped;
  logic [6:0] y1_clamped;
  logic       bad_rect;

`ifdef RECT_FILL_COLOUR_EN
  logic [7:0] colour_q, colour_d;
`else
  logic unused_colour;
  assign unused_colour = ^COLOUR;
`endif

  assign x1_clamped = (X1 > XMaxC) ? XMaxC : X1;
  assign y1_clamped = (Y1 > YMaxC) ? YMaxC : Y1;

  // row_q still holds Y0 in the first busy state, so this tests the latched
  // bounds. After a valid start row_q never passes y1_q, so it stays low.
  assign bad_rect = (x0_q > x1_q) || (row_q > y1_q);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q  <= StIdle;
      x0_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      col_q    <= '0;
      row_q    <= '0;
      pixel_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef RECT_FILL_COLOUR_EN
      colour_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      col_q    <= col_d;
      row_q    <= row_d;
      pixel_q  <= pixel_d;
      err_q    <= err_d;
`ifdef RECT_FILL_COLOUR_EN
      colour_q <= colour_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    x0_d         = x0_q;
    x1_d         = x1_q;
    y1_d         = y1_q;
    col_d        = col_q;
    row_d        = row_q;
    pixel_d      = pixel_q;
    err_d        = err_q;
`ifdef RECT_FILL_COLOUR_EN
    colour_d     = colour_q;
`endif
    BUS_ADDR     = 8'hFF;
    BUS_DATA_OUT = 8'h00;
    BUS_DATA_OE  = 1'b0;
    BUS_WE       = 1'b0;
    BUSY         = 1'b0;
    DONE         = 1'b0;
    ERR          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (START) begin
          x0_d     = X0;
          x1_d     = x1_clamped;
          y1_d     = y1_clamped;
          col_d    = X0;
          row_d    = Y0;
          pixel_d  = PIXEL;
          err_d    = 1'b0;
`ifdef RECT_FILL_COLOUR_EN
          colour_d = COLOUR;
`endif
          state_d  = StFirst;
        end
      end

`ifdef RECT_FILL_COLOUR_EN
      StColour: begin
        BUSY = 1'b1;
        if (bad_rect) begin
          err_d   = 1'b1;
          state_d = StFin;
        end else if (GRANT) begin
          BUS_ADDR     = AddrColour;
          BUS_DATA_OUT = colour_q;
          BUS_DATA_OE  = 1'b1;
          BUS_WE       = 1'b1;
          state_d      = StWrY;
        end
      end
`endif

      StWrY: begin
        BUSY = 1'b1;
        if (bad_rect) begin
          // Rejected rectangle: nothing is written.
          err_d   = 1'b1;
          state_d = StFin;
        end else if (GRANT) begin
          BUS_ADDR     = AddrRow;
          BUS_DATA_OUT = {1'b0, row_q};
          BUS_DATA_OE  = 1'b1;
          BUS_WE       = 1'b1;
          state_d      = StWrX;
        end
      end

      StWrX: begin
        BUSY = 1'b1;
        if (GRANT) begin
          BUS_ADDR     = AddrCol;
          BUS_DATA_OUT = col_q;
          BUS_DATA_OE  = 1'b1;
          BUS_WE       = 1'b1;
          state_d      = StWrPix;
        end
      end

      StWrPix: begin
        BUSY = 1'b1;
        if (GRANT) begin
          BUS_ADDR     = AddrPix;
          BUS_DATA_OUT = {7'b0, pixel_q};
          BUS_DATA_OE  = 1'b1;
          BUS_WE       = 1'b1;
          // Compare before incrementing so bounds at X_MAX/Y_MAX never wrap.
          if (col_q == x1_q) begin
            if (row_q == y1_q) begin
              state_d = StFin;
            end else begin
              row_d   = row_q + 7'd1;
              col_d   = x0_q;
              state_d = StWrY;
            end
          end else begin
            col_d   = col_q + 8'd1;
            state_d = StWrX;
          end
        end
      end

      StFin: begin
        DONE    = 1'b1;
        ERR     = err_q;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_rect_fill_master.sv
// Self-checking bench for rect_fill_master: a table of rectangles with
// hand-counted write totals, each write checked against a reference list of
// the expected bus writes, plus a hand-written mid-fill reset sequence.
module tb_rect_fill_master;

`ifdef RECT_FILL_COLOUR_EN
  localparam int Extra = 1;
`else
  localparam int Extra = 0;
`endif

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic       START = 1'b0;
  logic [7:0] X0 = '0, X1 = '0;
  logic [6:0] Y0 = '0, Y1 = '0;
  logic       PIXEL = 1'b0;
  logic [7:0] COLOUR = '0;
  logic       GRANT = 1'b1;
  logic [7:0] BUS_ADDR, BUS_DATA_OUT;
  logic       BUS_DATA_OE, BUS_WE, BUSY, DONE, ERR;

  rect_fill_master dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .START       (START),
    .X0          (X0),
    .X1          (X1),
    .Y0          (Y0),
    .Y1          (Y1),
    .PIXEL       (PIXEL),
    .COLOUR      (COLOUR),
    .GRANT       (GRANT),
    .BUS_ADDR    (BUS_ADDR),
    .BUS_DATA_OUT(BUS_DATA_OUT),
    .BUS_DATA_OE (BUS_DATA_OE),
    .BUS_WE      (BUS_WE),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .ERR         (ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] x0;
    logic [7:0] x1;
    logic [6:0] y0;
    logic [6:0] y1;
    logic       pix;
    logic [7:0] col;
    int         gap_at;
    int         gap_len;
    int         exp_n;    // hand-counted writes without the colour write
    logic       exp_err;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [15:0] got[$];
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference list of bus writes, derived directly from the fill order.
  task automatic build_model(input vec_t v);
    int x0, x1c, y0, y1c;
    exp_q.delete();
    x0  = int'(v.x0);
    y0  = int'(v.y0);
    x1c = (int'(v.x1) > 159) ? 159 : int'(v.x1);
    y1c = (int'(v.y1) > 119) ? 119 : int'(v.y1);
    if (x0 > x1c || y0 > y1c) return;
`ifdef RECT_FILL_COLOUR_EN
    exp_q.push_back({8'hB3, v.col});
`endif
    for (int r = y0; r <= y1c; r++) begin
      exp_q.push_back({8'hB1, 8'(r)});
      for (int c = x0; c <= x1c; c++) begin
        exp_q.push_back({8'hB0, 8'(c)});
        exp_q.push_back({8'hB2, 7'b0, v.pix});
      end
    end
  endtask

  // Issue START, then watch the bus until DONE. START stays high and the
  // operand inputs are scrambled while busy; none of that may matter.
  task automatic do_fill(input vec_t v, output int done_cyc, output logic err_out);
    bit in_gap;
    got.delete();
    done_cyc = -1;
    err_out  = 1'b0;
    @(posedge CLK); #1;
    X0 = v.x0; X1 = v.x1; Y0 = v.y0; Y1 = v.y1;
    PIXEL = v.pix; COLOUR = v.col; START = 1'b1; GRANT = 1'b1;
    @(negedge CLK);
    chk("start_cycle_we", BUS_WE, 1'b0);
    for (int c = 1; c <= 300; c++) begin
      @(posedge CLK); #1;
      in_gap = (v.gap_len > 0) && (c >= v.gap_at) && (c < v.gap_at + v.gap_len);
      GRANT  = !in_gap;
      X0 = 8'($urandom); X1 = 8'($urandom); Y0 = 7'($urandom); Y1 = 7'($urandom);
      PIXEL = 1'($urandom); COLOUR = 8'($urandom); START = 1'b1;
      @(negedge CLK);
      if (!GRANT) begin
        chk("gap_we", BUS_WE, 1'b0);
        chk("gap_addr", BUS_ADDR, 8'hFF);
        chk("gap_oe", BUS_DATA_OE, 1'b0);
      end
      if (BUS_WE) begin
        got.push_back({BUS_ADDR, BUS_DATA_OUT});
        chk("write_oe", BUS_DATA_OE, 1'b1);
      end
      if (DONE) begin
        done_cyc = c;
        err_out  = ERR;
        chk("busy_in_fin", BUSY, 1'b0);
        break;
      end
      chk("busy", BUSY, 1'b1);
    end
    if (done_cyc < 0) chk("done_timeout", 1'b0, 1'b1);
    @(posedge CLK); #1;
    START = 1'b0; GRANT = 1'b1;
    @(negedge CLK);
    chk("idle_after_done", {BUSY, DONE, BUS_WE}, 3'b000);
  endtask

  task automatic compare_writes(input string tag);
    int n;
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    chk({tag, "_model_count"}, got.size(), exp_q.size());
    for (int i = 0; i < n; i++) chk({tag, "_write"}, got[i], exp_q[i]);
  endtask

  vec_t vecs[10];

  initial begin
    vec_t v4;
    int   done_cyc;
    logic err_out;
    int   nwr;

    //           x0      x1      y0      y1      pix   col    gap_at     len n   err
    vecs[0] = '{8'd5,   8'd5,   7'd7,   7'd7,   1'b1, 8'h00, 0,         0, 3,  1'b0};
    vecs[1] = '{8'd0,   8'd1,   7'd0,   7'd1,   1'b0, 8'hE0, 0,         0, 10, 1'b0};
    vecs[2] = '{8'd10,  8'd4,   7'd0,   7'd0,   1'b1, 8'h11, 0,         0, 0,  1'b1};
    vecs[3] = '{8'd158, 8'd200, 7'd3,   7'd3,   1'b1, 8'h22, 0,         0, 5,  1'b0};
    vecs[4] = '{8'd2,   8'd2,   7'd3,   7'd3,   1'b1, 8'h33, 2 + Extra, 3, 3,  1'b0};
    vecs[5] = '{8'd157, 8'd159, 7'd117, 7'd119, 1'b1, 8'h44, 0,         0, 21, 1'b0};
    vecs[6] = '{8'd0,   8'd0,   7'd5,   7'd4,   1'b1, 8'h55, 0,         0, 0,  1'b1};
    vecs[7] = '{8'd0,   8'd0,   7'd118, 7'd127, 1'b1, 8'h66, 0,         0, 6,  1'b0};
    vecs[8] = '{8'd200, 8'd255, 7'd0,   7'd0,   1'b1, 8'h77, 0,         0, 0,  1'b1};
    vecs[9] = '{8'd0,   8'd3,   7'd0,   7'd3,   1'b0, 8'h88, 0,         0, 36, 1'b0};

    // Reset state
    @(negedge CLK);
    chk("rst_addr", BUS_ADDR, 8'hFF);
    chk("rst_data", BUS_DATA_OUT, 8'h00);
    chk("rst_ctl", {BUS_DATA_OE, BUS_WE, BUSY, DONE, ERR}, 5'b0);
    @(posedge CLK); #1;
    Reset = 1'b0;
    @(negedge CLK);
    chk("idle_no_write", {BUS_WE, BUSY, DONE}, 3'b000);
    chk("idle_addr", BUS_ADDR, 8'hFF);

    foreach (vecs[i]) begin
      build_model(vecs[i]);
      do_fill(vecs[i], done_cyc, err_out);
      nwr = vecs[i].exp_n + (vecs[i].exp_err ? 0 : Extra);
      chk($sformatf("v%0d_nwrites", i), got.size(), nwr);
      compare_writes($sformatf("v%0d", i));
      chk($sformatf("v%0d_err", i), err_out, vecs[i].exp_err);
      chk($sformatf("v%0d_done_cycle", i), done_cyc,
          vecs[i].exp_err ? 2 : nwr + 1 + vecs[i].gap_len);
    end

    // Reset in the middle of a 4x4 fill, after the third write.
    v4 = '{8'd0, 8'd3, 7'd0, 7'd3, 1'b1, 8'h5A, 0, 0, 36, 1'b0};
    nwr = 0;
    @(posedge CLK); #1;
    X0 = v4.x0; X1 = v4.x1; Y0 = v4.y0; Y1 = v4.y1;
    PIXEL = v4.pix; COLOUR = v4.col; START = 1'b1; GRANT = 1'b1;
    for (int c = 0; c < 20 && nwr < 3; c++) begin
      @(negedge CLK);
      if (BUS_WE) nwr++;
      if (c == 0) begin
        @(posedge CLK); #1;
        START = 1'b0;
        @(negedge CLK);
        if (BUS_WE) nwr++;
      end
      if (nwr < 3) @(posedge CLK);
    end
    chk("mid_reset_reached", nwr, 3);
    #2 Reset = 1'b1;
    #1;
    chk("async_rst_addr", BUS_ADDR, 8'hFF);
    chk("async_rst_data", BUS_DATA_OUT, 8'h00);
    chk("async_rst_ctl", {BUS_DATA_OE, BUS_WE, BUSY, DONE, ERR}, 5'b0);
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      chk("in_reset_done", DONE, 1'b0);
    end
    @(posedge CLK); #1;
    Reset = 1'b0;
    @(negedge CLK);
    chk("post_reset_idle", {DONE, BUSY, BUS_WE}, 3'b000);

    build_model(v4);
    do_fill(v4, done_cyc, err_out);
    chk("refill_nwrites", got.size(), 36 + Extra);
    compare_writes("refill");
    chk("refill_err", err_out, 1'b0);
    chk("refill_done_cycle", done_cyc, 36 + Extra + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
